tcm_axis_tx: RTL and testbench

TCM_AXIS_TX -- requirements
Module: tcm_axis_tx

---
 rtl/tcm_axis_tx.sv | 140 ++++++++++++++
 tb/tb_tcm_axis_tx.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/tcm_axis_tx.sv
// AXI4-Stream test-pattern frame generator: emits N beats of incrementing or
// LFSR data per start edge, with abort, sticky status and a frame counter.
module tcm_axis_tx #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int C_LEN_WIDTH          = 16
) (
  input  logic                              m_axis_aclk,
  input  logic                              m_axis_areset,
  input  logic [31:0]                       USR_tcm_control,
  input  logic [31:0]                       USR_tcm_seed,
  output logic [31:0]                       USR_tcm_status,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                              m_axis_tlast
);

  localparam int DW = C_M_AXIS_TDATA_WIDTH;
  localparam int LW = C_LEN_WIDTH;
  localparam logic [DW-1:0] LFSR_MASK = DW'(32'h8020_0003);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          state_q;
  logic            ctrl_start_q;
  logic            tvalid_q;
  logic            tlast_q;
  logic [DW-1:0]   tdata_q;
  logic [LW-1:0]   k_q;
  logic [LW-1:0]   n_q;
  logic            mode_q;
  logic            done_q;
  logic            aborted_q;
  logic            abort_pend_q;
  logic            abort_term_q;
  logic [15:0]     frame_cnt_q;

  logic            start_evt;
  logic            abort_in;
  logic            mode_in;
  logic [LW-1:0]   n_in;
  logic [DW-1:0]   seed_w;
  logic [DW-1:0]   first_d;
  logic [DW-1:0]   beat_d;
  logic [LW-1:0]   k_d;
  logic            handshake;
  logic            abort_now;
  logic            unused_ctrl;

  assign start_evt   = USR_tcm_control[0] & ~ctrl_start_q;
  assign mode_in     = USR_tcm_control[1];
  assign abort_in    = USR_tcm_control[2];
  assign n_in        = LW'(USR_tcm_control[31:16]);
  assign seed_w      = DW'(USR_tcm_seed);
  assign unused_ctrl = ^USR_tcm_control[15:3];

  assign handshake = tvalid_q & m_axis_tready;
  // An abort seen on the same edge as a handshake already shortens the beat being loaded.
  assign abort_now = abort_pend_q | abort_in;
  assign k_d       = k_q + 1'b1;

  always_comb begin
    first_d = seed_w;
    if (mode_in && seed_w == '0) first_d = {{(DW-1){1'b0}}, 1'b1};
    if (mode_q) beat_d = (tdata_q >> 1) ^ (tdata_q[0] ? LFSR_MASK : '0);
    else        beat_d = tdata_q + 1'b1;
  end

  // NOTE: every state register is updated with <= so all of them sample the
  // same pre-edge values; a blocking = here would create ordering-dependent logic.
  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      state_q      <= IDLE;
      ctrl_start_q <= 1'b0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tdata_q      <= '0;
      k_q          <= '0;
      n_q          <= '0;
      mode_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      abort_term_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      ctrl_start_q <= USR_tcm_control[0];
      case (state_q)
        IDLE: begin
          if (start_evt && n_in != '0 && !abort_in) begin
            state_q      <= SEND;
            tvalid_q     <= 1'b1;
            tdata_q      <= first_d;
            tlast_q      <= (n_in == LW'(1));
            k_q          <= '0;
            n_q          <= n_in;
            mode_q       <= mode_in;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            abort_term_q <= 1'b0;
          end
        end
        SEND: begin
          if (abort_in) abort_pend_q <= 1'b1;
          if (handshake) begin
            if (tlast_q) begin
              state_q      <= IDLE;
              tvalid_q     <= 1'b0;
              tlast_q      <= 1'b0;
              done_q       <= 1'b1;
              aborted_q    <= abort_term_q;
              frame_cnt_q  <= frame_cnt_q + 16'd1;
              abort_pend_q <= 1'b0;
              abort_term_q <= 1'b0;
            end else begin
              k_q          <= k_d;
              tdata_q      <= beat_d;
              tlast_q      <= (k_d == n_q - 1'b1) | abort_now;
              // Remember that this tlast came from an abort, not the beat count.
              abort_term_q <= abort_now;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_axis_tvalid  = tvalid_q;
  assign m_axis_tdata   = tdata_q;
  assign m_axis_tlast   = tlast_q;
  assign m_axis_tstrb   = '1;
  assign USR_tcm_status = {frame_cnt_q, 13'd0, aborted_q, done_q, (state_q == SEND)};

endmodule

// File: tb/tb_tcm_axis_tx.sv
// Directed bench for tcm_axis_tx: a per-cycle vector table for the basic
// frames followed by hand-written abort, ignore and reset sequences.
module tb_tcm_axis_tx;

  localparam logic [2:0] ST = 3'b001;
  localparam logic [2:0] MD = 3'b010;
  localparam logic [2:0] AB = 3'b100;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ctrl;
  logic [31:0] seed;
  logic [31:0] status;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tlast;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic [31:0] ctrl;
    logic [31:0] seed;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic [31:0] es;
  } vec_t;

  vec_t tbl[20];

  tcm_axis_tx #(
    .C_M_AXIS_TDATA_WIDTH(32),
    .C_LEN_WIDTH         (16)
  ) dut (
    .m_axis_aclk    (clk),
    .m_axis_areset  (rst),
    .USR_tcm_control(ctrl),
    .USR_tcm_seed   (seed),
    .USR_tcm_status (status),
    .m_axis_tvalid  (tvalid),
    .m_axis_tready  (tready),
    .m_axis_tdata   (tdata),
    .m_axis_tstrb   (tstrb),
    .m_axis_tlast   (tlast)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ctl(input int n, input logic [2:0] bits);
    return {n[15:0], 13'd0, bits};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock once, then compare the registered outputs.
  task automatic step(input string nm, input logic r, input logic [31:0] c,
                      input logic [31:0] s, input logic rd, input logic ev,
                      input logic [31:0] ed, input logic el, input logic [31:0] es);
    @(negedge clk);
    rst = r; ctrl = c; seed = s; tready = rd;
    @(posedge clk);
    #1;
    check({nm, " tvalid"}, 32'(tvalid), 32'(ev));
    check({nm, " tlast"},  32'(tlast),  32'(el));
    check({nm, " status"}, status, es);
    check({nm, " tstrb"},  32'(tstrb),  32'hF);
    if (ev) check({nm, " tdata"}, tdata, ed);
  endtask

  initial begin
    rst = 1'b1; ctrl = '0; seed = '0; tready = 1'b0;

    // rst, ctrl, seed, tready, exp tvalid, exp tdata, exp tlast, exp status
    tbl[0]  = '{1'b1, 32'h0,          32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[1]  = '{1'b0, ctl(4, ST),     32'h10,       1'b1, 1'b1, 32'h10,       1'b0, 32'h0000_0001};
    tbl[2]  = '{1'b0, ctl(4, ST),     32'h10,       1'b1, 1'b1, 32'h11,       1'b0, 32'h0000_0001};
    tbl[3]  = '{1'b0, ctl(4, ST),     32'h10,       1'b1, 1'b1, 32'h12,       1'b0, 32'h0000_0001};
    tbl[4]  = '{1'b0, ctl(4, ST),     32'h10,       1'b1, 1'b1, 32'h13,       1'b1, 32'h0000_0001};
    tbl[5]  = '{1'b0, ctl(4, ST),     32'h10,       1'b1, 1'b0, 32'h0,        1'b0, 32'h0001_0002};
    tbl[6]  = '{1'b0, 32'h0,          32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0001_0002};
    tbl[7]  = '{1'b0, ctl(3, ST),     32'hFFFF_FFFE, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0001_0001};
    tbl[8]  = '{1'b0, ctl(3, ST),     32'hFFFF_FFFE, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0001_0001};
    tbl[9]  = '{1'b0, ctl(3, ST),     32'hFFFF_FFFE, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0001_0001};
    tbl[10] = '{1'b0, ctl(3, ST),     32'hFFFF_FFFE, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0001_0001};
    tbl[11] = '{1'b0, ctl(3, ST),     32'hFFFF_FFFE, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 32'h0001_0001};
    tbl[12] = '{1'b0, ctl(3, ST),     32'hFFFF_FFFE, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 32'h0001_0001};
    tbl[13] = '{1'b0, ctl(3, ST),     32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0002_0002};
    tbl[14] = '{1'b0, 32'h0,          32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0002_0002};
    tbl[15] = '{1'b0, ctl(3, ST | MD), 32'h0,       1'b1, 1'b1, 32'h0000_0001, 1'b0, 32'h0002_0001};
    tbl[16] = '{1'b0, ctl(3, ST | MD), 32'h0,       1'b1, 1'b1, 32'h8020_0003, 1'b0, 32'h0002_0001};
    tbl[17] = '{1'b0, ctl(3, ST | MD), 32'h0,       1'b1, 1'b1, 32'hC030_0002, 1'b1, 32'h0002_0001};
    tbl[18] = '{1'b0, ctl(3, ST | MD), 32'h0,       1'b1, 1'b0, 32'h0,        1'b0, 32'h0003_0002};
    tbl[19] = '{1'b0, 32'h0,          32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0003_0002};

    for (int i = 0; i < 20; i++)
      step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].ctrl, tbl[i].seed, tbl[i].rdy,
           tbl[i].ev, tbl[i].ed, tbl[i].el, tbl[i].es);

    // Abort raised on the beat-2 handshake: beat 3 becomes the last one.
    step("ab_b0", 0, ctl(8, ST),      32'h100, 1, 1, 32'h100, 0, 32'h0003_0001);
    step("ab_b1", 0, ctl(8, ST),      32'h100, 1, 1, 32'h101, 0, 32'h0003_0001);
    step("ab_b2", 0, ctl(8, ST),      32'h100, 1, 1, 32'h102, 0, 32'h0003_0001);
    step("ab_b3", 0, ctl(8, ST | AB), 32'h100, 1, 1, 32'h103, 1, 32'h0003_0001);
    step("ab_end", 0, ctl(8, ST),     32'h100, 1, 0, 32'h0,   0, 32'h0004_0006);
    step("ab_idle", 0, 32'h0,         32'h0,   1, 0, 32'h0,   0, 32'h0004_0006);

    // Ignored starts, abort on a beat that already carries tlast, idle abort.
    step("n0_start",  0, ctl(0, ST),      32'h77, 1, 0, 32'h0,  0, 32'h0004_0006);
    step("n0_rel",    0, 32'h0,           32'h0,  0, 0, 32'h0,  0, 32'h0004_0006);
    step("n2_start",  0, ctl(2, ST),      32'h20, 0, 1, 32'h20, 0, 32'h0004_0001);
    step("n2_hold",   0, 32'h0,           32'h0,  0, 1, 32'h20, 0, 32'h0004_0001);
    step("send_strt", 0, ctl(1, ST),      32'h99, 0, 1, 32'h20, 0, 32'h0004_0001);
    step("n2_b1",     0, 32'h0,           32'h0,  1, 1, 32'h21, 1, 32'h0004_0001);
    step("last_ab",   0, ctl(0, AB),      32'h0,  0, 1, 32'h21, 1, 32'h0004_0001);
    step("last_end",  0, 32'h0,           32'h0,  1, 0, 32'h0,  0, 32'h0005_0002);
    step("n1_start",  0, ctl(1, ST),      32'h55, 0, 1, 32'h55, 1, 32'h0005_0001);
    step("n1_end",    0, 32'h0,           32'h0,  1, 0, 32'h0,  0, 32'h0006_0002);
    step("idle_ab",   0, ctl(0, AB),      32'h0,  1, 0, 32'h0,  0, 32'h0006_0002);
    step("ab_start",  0, ctl(2, ST | AB), 32'h5,  1, 0, 32'h0,  0, 32'h0006_0002);
    step("rel",       0, 32'h0,           32'h0,  1, 0, 32'h0,  0, 32'h0006_0002);

    // Reset in the middle of a frame, then a clean restart from the seed.
    step("rs_b0",   0, ctl(5, ST), 32'h40, 1, 1, 32'h40, 0, 32'h0006_0001);
    step("rs_b1",   0, ctl(5, ST), 32'h40, 1, 1, 32'h41, 0, 32'h0006_0001);
    step("rs_b2",   0, ctl(5, ST), 32'h40, 1, 1, 32'h42, 0, 32'h0006_0001);
    step("rs_rst",  1, 32'h0,      32'h0,  1, 0, 32'h0,  0, 32'h0);
    step("rs_idle", 0, 32'h0,      32'h0,  1, 0, 32'h0,  0, 32'h0);
    step("rs_new",  0, ctl(5, ST), 32'h40, 1, 1, 32'h40, 0, 32'h0000_0001);
    for (int k = 1; k < 5; k++)
      step($sformatf("rs_beat%0d", k), 0, ctl(5, ST), 32'h40, 1, 1,
           32'h40 + 32'(k), (k == 4), 32'h0000_0001);
    step("rs_end", 0, 32'h0, 32'h0, 1, 0, 32'h0, 0, 32'h0001_0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
